// File: rtl/serial_link_obi_arbiter.sv
// Round-robin arbiter sharing the serial link bridge OBI slave port between NumReq masters,
// with an in-order ID FIFO routing responses back. Optional grant counters: SERIAL_LINK_OBI_ARB_PERF_EN.
module serial_link_obi_arbiter #(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumReq-1:0]               req_i,
    output logic [NumReq-1:0]               gnt_o,
    input  logic [NumReq*AddrWidth-1:0]     addr_i,
    input  logic [NumReq-1:0]               we_i,
    input  logic [NumReq*(DataWidth/8)-1:0] be_i,
    input  logic [NumReq*DataWidth-1:0]     wdata_i,
    output logic [NumReq-1:0]               rvalid_o,
    output logic [DataWidth-1:0]            rdata_o,
    output logic                            mst_req_o,
    input  logic                            mst_gnt_i,
    output logic [AddrWidth-1:0]            mst_addr_o,
    output logic                            mst_we_o,
    output logic [DataWidth/8-1:0]          mst_be_o,
    output logic [DataWidth-1:0]            mst_wdata_o,
    input  logic                            mst_rvalid_i,
    input  logic [DataWidth-1:0]            mst_rdata_i,
    output logic                            err_o
`ifdef SERIAL_LINK_OBI_ARB_PERF_EN
    ,
    output logic [NumReq*16-1:0]            grant_cnt_o
`endif
);

    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned IdWidth  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned PtrWidth = $clog2(MaxOutstanding);
    localparam int unsigned CntWidth = PtrWidth + 1;

    typedef logic [IdWidth-1:0]  id_t;
    typedef logic [IdWidth:0]    cand_t;
    typedef logic [PtrWidth-1:0] ptr_t;
    typedef logic [CntWidth-1:0] cnt_t;

    id_t   rr_q;
    id_t   winner;
    logic  found;
    cand_t cand;

    ptr_t  rd_ptr_q;
    ptr_t  wr_ptr_q;
    cnt_t  count_q;
    logic  err_q;
    id_t   fifo_q [MaxOutstanding];

    logic  full;
    logic  empty;
    logic  accept;
    logic  pop;
    id_t   head_id;

    // Winner search: first asserted request at or above rr_q, wrapping past NumReq-1.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
        winner = rr_q;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = {1'b0, rr_q} + cand_t'(i);
            if (cand >= cand_t'(NumReq)) begin
                cand = cand - cand_t'(NumReq);
            end
            if (!found && req_i[cand[IdWidth-1:0]]) begin
                winner = cand[IdWidth-1:0];
                found  = 1'b1;
            end
        end
    end

    assign full    = (count_q == cnt_t'(MaxOutstanding));
    assign empty   = (count_q == '0);
    assign accept  = mst_req_o && mst_gnt_i;
    assign pop     = mst_rvalid_i && !empty;
    assign head_id = fifo_q[rd_ptr_q];

    // Full blocks new requests even when a response frees a slot in the same cycle.
    assign mst_req_o   = (|req_i) && !full;
    assign mst_addr_o  = addr_i[winner*AddrWidth +: AddrWidth];
    assign mst_we_o    = we_i[winner];
    assign mst_be_o    = be_i[winner*BeWidth +: BeWidth];
    assign mst_wdata_o = wdata_i[winner*DataWidth +: DataWidth];

    assign rdata_o = mst_rdata_i;
    assign err_o   = err_q;

    always_comb begin
        gnt_o = '0;
        if (accept) begin
            gnt_o[winner] = 1'b1;
        end
    end

    always_comb begin
        rvalid_o = '0;
        if (pop) begin
            rvalid_o[head_id] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            rr_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                rr_q     <= (winner == id_t'(NumReq - 1)) ? '0 : winner + id_t'(1);
                wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
            // Response with nothing outstanding (including leftovers from before a reset).
            if (mst_rvalid_i && empty) begin
                err_q <= 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + cnt_t'(1);
                2'b01:   count_q <= count_q - cnt_t'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the ID storage has no reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            fifo_q[wr_ptr_q] <= winner;
        end
    end

`ifdef SERIAL_LINK_OBI_ARB_PERF_EN
    logic [15:0] grant_cnt_q [NumReq];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < NumReq; k++) begin
                grant_cnt_q[k] <= '0;
            end
        end else if (accept && (grant_cnt_q[winner] != 16'hFFFF)) begin
            grant_cnt_q[winner] <= grant_cnt_q[winner] + 16'd1;
        end
    end

    always_comb begin
        grant_cnt_o = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            grant_cnt_o[k*16 +: 16] = grant_cnt_q[k];
        end
    end
`endif

endmodule
